// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: digit width,
// FSM state encoding and elaboration-time sizing helpers.
package bin2bcd_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

  // Number of decimal digits needed to hold 2^in_w - 1.
  function automatic int scr_digits(input int in_w);
    int v;
    int n;
    v = (1 << in_w) - 1;
    n = 0;
    while (v > 0) begin
      n++;
      v = v / 10;
    end
    return n;
  endfunction

  // Largest value representable in 'digits' decimal digits: 10^digits - 1.
  function automatic int max_val(input int digits);
    int p;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    return p - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between the binary source (master) and the
// bin2bcd_seq converter (slave).
interface bin2bcd_seq_if #(
  parameter int IN_W = 7
);
  import bin2bcd_pkg::*;

  logic               start;
  logic [IN_W-1:0]    bin_in;
  logic               busy;
  logic               done;
  logic [DIGIT_W-1:0] ones;
  logic [DIGIT_W-1:0] tens;
  logic               ovf;

  modport master (
    output start, bin_in,
    input  busy, done, ones, tens, ovf
  );

  modport slave (
    input  start, bin_in,
    output busy, done, ones, tens, ovf
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or
// more, so the following left shift carries correctly into the next digit.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_in,
  output logic [DIGIT_W-1:0] d_out
);

  // Add-3 correction ahead of the shift.
  always_comb begin
    d_out = (d_in >= DIGIT_W'(5)) ? d_in + DIGIT_W'(3) : d_in;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Presents registered tens/ones digits with a one-cycle done pulse.
// Build option: define BIN2BCD_SATURATE_EN to show 9,9 whenever the operand
// exceeds the displayable range; otherwise the low two true digits are shown.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int IN_W   = 7,
  parameter int DIGITS = 2
) (
  input  logic         CLK_50MHZ,
  input  logic         RST_N,
  bin2bcd_seq_if.slave bus
);

  localparam int          SCR_DIGITS = scr_digits(IN_W);
  localparam int          SCR_W      = SCR_DIGITS * DIGIT_W;
  localparam int          CNT_W      = $clog2(IN_W + 1);
  localparam logic [31:0] MAX_OUT    = 32'(max_val(DIGITS));

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_CONV = CONV;

  logic [0:0]         state_q, state_d;
  logic [IN_W-1:0]    sh_q, sh_d;
  logic [SCR_W-1:0]   scr_q, scr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [DIGIT_W-1:0] ones_q, ones_d;
  logic [DIGIT_W-1:0] tens_q, tens_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic [SCR_W-1:0]      scr_adj;
  logic [SCR_W+IN_W-1:0] cat_shift;
  logic [SCR_W-1:0]      scr_shift;
  logic [IN_W-1:0]       sh_shift;
  logic [31:0]           bin_ext;

  // One add-3 corrector per scratch digit.
  for (genvar g = 0; g < SCR_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_in  (scr_q[g*DIGIT_W +: DIGIT_W]),
      .d_out (scr_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign cat_shift = {scr_adj, sh_q} << 1;
  assign scr_shift = cat_shift[SCR_W+IN_W-1:IN_W];
  assign sh_shift  = cat_shift[IN_W-1:0];
  assign bin_ext   = 32'(bus.bin_in);

  // Next-state logic: operand capture in IDLE, one adjust+shift per CONV cycle.
  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d    = state_q;
    sh_d       = sh_q;
    scr_d      = scr_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    ones_d     = ones_q;
    tens_d     = tens_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_CONV;
          sh_d       = bus.bin_in;
          scr_d      = '0;
          cnt_d      = CNT_W'(IN_W);
          ovf_pend_d = (bin_ext > MAX_OUT);
        end
      end
      ST_CONV: begin
        sh_d  = sh_shift;
        scr_d = scr_shift;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Last bit shifted in: publish the result from the final scratch.
          state_d = ST_IDLE;
          done_d  = 1'b1;
          ovf_d   = ovf_pend_q;
`ifdef BIN2BCD_SATURATE_EN
          if (ovf_pend_q) begin
            ones_d = DIGIT_W'(9);
            tens_d = DIGIT_W'(9);
          end else begin
            ones_d = scr_shift[DIGIT_W-1:0];
            tens_d = scr_shift[2*DIGIT_W-1:DIGIT_W];
          end
`else
          ones_d = scr_shift[DIGIT_W-1:0];
          tens_d = scr_shift[2*DIGIT_W-1:DIGIT_W];
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything, including results.
  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      sh_q       <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      ones_q     <= '0;
      tens_q     <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q    <= state_d;
      sh_q       <= sh_d;
      scr_q      <= scr_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      ones_q     <= ones_d;
      tens_q     <= tens_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy = (state_q == ST_CONV);
  assign bus.done = done_q;
  assign bus.ones = ones_q;
  assign bus.tens = tens_q;
  assign bus.ovf  = ovf_q;

endmodule
